scanning_multiplexer: RTL and testbench
=======================================

Name: scanning_multiplexer

Overview:
- Parametrised N-to-1 multiplexer with a registered output and a valid/ready output handshake.
- Two modes:
  - Manual: the channel is chosen by `s`.
  - Scan: an internal pointer cycles through the channels, holding each for DWELL accepted samples.
- Sits between multi-channel sensor/data sources and a single downstream consumer.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 8, number of input channels (2..256).
- SEL_W, 3, select/pointer width; must satisfy 2**SEL_W >= CHANNELS.
- DWELL, 1, accepted samples per channel before the scan pointer advances (1..255).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- i  input  CHANNELS*WIDTH  packed channel data; channel k = i[k*WIDTH +: WIDTH].
- s  input  SEL_W  manual channel select.
- scan  input  1  1 = scan mode, 0 = manual mode.
- en  input  1  enables loading of new samples.
- out_ready  input  1  downstream accepts the current sample.
- out  output  WIDTH  registered selected data.
- out_ch  output  SEL_W  channel index that produced out.
- out_valid  output  1  out/out_ch hold a sample not yet accepted.
- wrap  output  1  marks the sample that completed a full scan cycle.

Behaviour:
- Reset: all of the following clear to 0 immediately on rst_n low, asynchronously, regardless of clk:
  - outputs: out, out_ch, out_valid, wrap;
  - internal state: ch_ptr, dwell_cnt, scan_d.
- Reset mid-handshake discards the pending sample; no sample is emitted on the first edge after release unless the load rule is met.
- Load rule: load = en & (~out_valid | out_ready).
  - On a clk edge with load=1, out_valid<=1 and the selected channel is registered into out/out_ch.
  - On an edge with out_ready=1 and load=0, out_valid<=0.
- Stall: while out_valid=1 and out_ready=0, out, out_ch and wrap hold stable.
- Latency: one cycle from the input sampled to out.
- Channel selection:
  - Manual: the selected channel is s.
  - Scan: the selected channel is ch_ptr.
- Out-of-range select (s >= CHANNELS in manual mode): out loads 0 and out_ch loads s. This is not an error state.
- Scan pointer, advanced only on loads in scan mode:
  - dwell_cnt increments per load.
  - When dwell_cnt = DWELL-1: dwell_cnt<=0 and ch_ptr<=ch_ptr+1.
  - ch_ptr wraps from CHANNELS-1 to 0.
  - wrap loads 1 with the last sample of channel CHANNELS-1; otherwise wrap loads 0 on every load.
- Mode entry:
  - scan_d registers scan each cycle.
  - On the edge where scan=1 and scan_d=0, ch_ptr and dwell_cnt restart at 0, and that edge's load (if any) takes channel 0.
- Manual mode: ch_ptr and dwell_cnt hold.
- en=0: no loads occur. A pending sample still completes its handshake, then out_valid drops.
- Simultaneous events:
  - out_ready and load in the same cycle: the old sample is accepted and the new one loads (back-to-back throughput, one sample per cycle).
  - s change or mode change while stalled does not alter the held output.

Optional Feature:
- Macro: SCANNING_MULTIPLEXER_MASK_EN.
- Enabled:
  - Adds input port mask [CHANNELS-1:0]; a masked (1) channel is skipped in scan mode.
  - Pointer advance and scan-entry restart go to the next unmasked channel, wrapping, found combinationally within one cycle.
  - wrap loads 1 when the advance crosses from the highest unmasked channel.
  - All channels masked in scan mode: no loads occur and out_valid drops after acceptance.
  - Manual mode ignores mask.
- Disabled: no mask port; all channels are scanned.

Test Plan:
- Manual routing, stall and throughput:
  - Stimulus: CHANNELS=8, WIDTH=8, channel k=0x10+k, scan=0, en=1, out_ready=1, s=5.
  - Response: out=0x15, out_ch=5, out_valid=1 one cycle after en rises.
  - Stimulus: s steps 0..7 one per cycle.
  - Response: out follows with 1-cycle lag.
- Stall hold:
  - Stimulus: sample 0x13 valid, out_ready=0 for 4 cycles while s changes to 6.
  - Response: out=0x13 and out_ch=3 held; after out_ready=1, the next cycle out=0x16.
- Scan with DWELL:
  - Stimulus: DWELL=2, scan=1, out_ready=1.
  - Response: out_ch sequence 0,0,1,1,...,7,7,0; wrap=1 only on the second channel-7 sample.
- Mode re-entry:
  - Stimulus: scan 1->0 at ch_ptr=4, then 0->1.
  - Response: next scan sample has out_ch=0, dwell restarted.
- Asynchronous reset:
  - Stimulus: pull rst_n low mid-stall, between clock edges.
  - Response: out=0, out_valid=0, wrap=0 immediately.
  - After release with scan=1, the first sample is from channel 0.
- Mask (macro defined):
  - Stimulus: mask=8'b1010_0110, scan=1, DWELL=1.
  - Response: out_ch sequence 0,3,4,6,0; wrap=1 on the channel-6 sample.
  - Stimulus: mask=8'hFF.
  - Response: out_valid stays 0.

Source files
------------

// File: rtl/scanning_multiplexer.sv
// N-to-1 registered multiplexer with valid/ready output, manual or scanning channel selection.
// Define SCANNING_MULTIPLEXER_MASK_EN to add a per-channel skip mask for scan mode.
module scanning_multiplexer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned DWELL    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] i,
    input  logic [SEL_W-1:0]          s,
    input  logic                      scan,
    input  logic                      en,
`ifdef SCANNING_MULTIPLEXER_MASK_EN
    input  logic [CHANNELS-1:0]       mask,
`endif
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    output logic                      wrap
);

    localparam int unsigned      CNT_W      = 8;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    logic [WIDTH-1:0]    r_out;
    logic [SEL_W-1:0]    r_out_ch;
    logic                r_out_valid;
    logic                r_wrap;
    logic [SEL_W-1:0]    r_ch_ptr;
    logic [CNT_W-1:0]    r_dwell_cnt;
    logic                r_scan_d;

    logic [CHANNELS-1:0] w_mask;
    logic                w_entry;
    logic                w_load;
    logic                w_last;
    logic                w_wrap;
    logic [SEL_W-1:0]    w_ptr;
    logic [SEL_W-1:0]    w_succ;
    logic [SEL_W-1:0]    w_next;
    logic [SEL_W-1:0]    w_sel;
    logic [CNT_W-1:0]    w_cnt;
    logic [WIDTH-1:0]    w_data;

`ifdef SCANNING_MULTIPLEXER_MASK_EN
    assign w_mask = mask;
`else
    assign w_mask = '0;
`endif

    // Lowest unmasked channel at or above start, wrapping around to the lowest unmasked overall.
    function automatic logic [SEL_W-1:0] f_first_unmasked(input logic [SEL_W-1:0]    start,
                                                          input logic [CHANNELS-1:0] m);
        logic [SEL_W-1:0]    v_lo;
        logic [SEL_W-1:0]    v_hi;
        logic                v_found_lo;
        logic                v_found_hi;
        logic [CHANNELS-1:0] v_m;
        v_lo       = '0;
        v_hi       = '0;
        v_found_lo = 1'b0;
        v_found_hi = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            v_m = m >> c;
            if (!v_m[0] && !v_found_lo) begin
                v_found_lo = 1'b1;
                v_lo       = SEL_W'(c);
            end
            if (!v_m[0] && !v_found_hi && (c >= 32'(start))) begin
                v_found_hi = 1'b1;
                v_hi       = SEL_W'(c);
            end
        end
        return v_found_hi ? v_hi : v_lo;
    endfunction

    // Effective scan position (restart on scan entry), successor and channel data select.
    always_comb begin
        w_entry = scan & ~r_scan_d;
        w_cnt   = w_entry ? '0 : r_dwell_cnt;
        w_ptr   = f_first_unmasked(w_entry ? SEL_W'(0) : r_ch_ptr, w_mask);
        w_succ  = w_ptr + SEL_W'(1);
        w_next  = f_first_unmasked(w_succ, w_mask);
        w_wrap  = (w_next <= w_ptr);
        w_last  = (w_cnt == DWELL_LAST);
        w_sel   = scan ? w_ptr : s;
        w_load  = en & (~r_out_valid | out_ready) & ~(scan & (&w_mask));
        w_data  = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (SEL_W'(c) == w_sel) w_data = WIDTH'(i >> (c * WIDTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
            r_ch_ptr    <= '0;
            r_dwell_cnt <= '0;
            r_scan_d    <= 1'b0;
        end else begin
            r_scan_d <= scan;
            if (w_load) begin
                r_out       <= w_data;
                r_out_ch    <= w_sel;
                r_out_valid <= 1'b1;
                r_wrap      <= scan & w_last & w_wrap;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            // Scan pointer only moves on scan-mode loads; entry restarts it even without a load.
            if (scan) begin
                if (w_load) begin
                    if (w_last) begin
                        r_dwell_cnt <= '0;
                        r_ch_ptr    <= w_next;
                    end else begin
                        r_dwell_cnt <= w_cnt + CNT_W'(1);
                        r_ch_ptr    <= w_ptr;
                    end
                end else if (w_entry) begin
                    r_dwell_cnt <= '0;
                    r_ch_ptr    <= w_ptr;
                end
            end
        end
    end

    assign out       = r_out;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_scanning_multiplexer.sv
// Randomized and directed bench for scanning_multiplexer: an 8-channel DWELL=2 instance and a
// 5-channel DWELL=1 instance (reachable out-of-range selects) checked against a sample-order model.
module tb_scanning_multiplexer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] tb_i;
    logic [2:0]  s;
    logic        scan;
    logic        en;
    logic        rdy;
    logic [7:0]  tb_mask;

    logic [7:0]  out0, out1;
    logic [2:0]  ch0, ch1;
    logic        v0, v1;
    logic        w0, w1;

    int          n_checks = 0;
    int          n_errors = 0;

    // Model state: position within one full scan period, plus the expected output registers.
    int          m_pos[2];
    logic        m_valid[2];
    logic [7:0]  m_out[2];
    logic [2:0]  m_ch[2];
    logic        m_wrap[2];
    logic        m_scan_d[2];

    always #5 clk = ~clk;

    scanning_multiplexer #(.WIDTH(8), .CHANNELS(8), .SEL_W(3), .DWELL(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i         (tb_i),
        .s         (s),
        .scan      (scan),
        .en        (en),
`ifdef SCANNING_MULTIPLEXER_MASK_EN
        .mask      (tb_mask),
`endif
        .out_ready (rdy),
        .out       (out0),
        .out_ch    (ch0),
        .out_valid (v0),
        .wrap      (w0)
    );

    scanning_multiplexer #(.WIDTH(8), .CHANNELS(5), .SEL_W(3), .DWELL(1)) u_dut_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .i         (tb_i[39:0]),
        .s         (s),
        .scan      (scan),
        .en        (en),
`ifdef SCANNING_MULTIPLEXER_MASK_EN
        .mask      (tb_mask[4:0]),
`endif
        .out_ready (rdy),
        .out       (out1),
        .out_ch    (ch1),
        .out_valid (v1),
        .wrap      (w1)
    );

    function automatic int nch(input int k);
        return (k == 0) ? 8 : 5;
    endfunction

    function automatic int dwl(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pos[k]    = 0;
            m_valid[k]  = 1'b0;
            m_out[k]    = 8'h00;
            m_ch[k]     = 3'd0;
            m_wrap[k]   = 1'b0;
            m_scan_d[k] = 1'b0;
        end
    endtask

    // Scan order is the list of unmasked channels, each repeated DWELL times; wrap marks the period end.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int lst[$];
            int per;
            int ch;
            bit ld;
            lst = {};
            for (int c = 0; c < nch(k); c++) begin
                if (((tb_mask >> c) & 8'h01) == 8'h00) lst.push_back(c);
            end
            per = lst.size() * dwl(k);
            if (scan && !m_scan_d[k]) m_pos[k] = 0;
            ld = en && (!m_valid[k] || rdy) && !(scan && (lst.size() == 0));
            if (ld) begin
                if (scan) begin
                    ch        = lst[m_pos[k] / dwl(k)];
                    m_wrap[k] = (m_pos[k] == per - 1);
                    m_pos[k]  = (m_pos[k] + 1) % per;
                end else begin
                    ch        = int'(s);
                    m_wrap[k] = 1'b0;
                end
                m_valid[k] = 1'b1;
                m_ch[k]    = 3'(ch);
                m_out[k]   = (ch < nch(k)) ? 8'(tb_i >> (ch * 8)) : 8'h00;
            end else if (rdy) begin
                m_valid[k] = 1'b0;
            end
            m_scan_d[k] = scan;
        end
    endtask

    task automatic compare_all();
        chk("valid0", 32'(v0),   32'(m_valid[0]));
        chk("out0",   32'(out0), 32'(m_out[0]));
        chk("ch0",    32'(ch0),  32'(m_ch[0]));
        chk("wrap0",  32'(w0),   32'(m_wrap[0]));
        chk("valid1", 32'(v1),   32'(m_valid[1]));
        chk("out1",   32'(out1), 32'(m_out[1]));
        chk("ch1",    32'(ch1),  32'(m_ch[1]));
        chk("wrap1",  32'(w1),   32'(m_wrap[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        rst_n   = 1'b0;
        tb_i    = '0;
        s       = 3'd0;
        scan    = 1'b0;
        en      = 1'b0;
        rdy     = 1'b0;
        tb_mask = 8'h00;
        model_reset();
        #12;
        chk("rst_out",   32'(out0), 32'h0);
        chk("rst_ch",    32'(ch0),  32'h0);
        chk("rst_valid", 32'(v0),   32'h0);
        chk("rst_wrap",  32'(w0),   32'h0);
        rst_n = 1'b1;
        step();

        // Manual routing: channel k carries 0x10+k
        tb_i = 64'h1716_1514_1312_1110;
        s    = 3'd5;
        en   = 1'b1;
        rdy  = 1'b1;
        step();
        chk("man_out",   32'(out0), 32'h15);
        chk("man_ch",    32'(ch0),  32'h5);
        chk("man_valid", 32'(v0),   32'h1);
        chk("oor_out",   32'(out1), 32'h0);
        chk("oor_ch",    32'(ch1),  32'h5);
        for (int n = 0; n < 8; n++) begin
            s = 3'(n);
            step();
            chk("sweep_out", 32'(out0), 32'h10 + 32'(n));
        end

        // Stall hold while s changes
        s = 3'd3;
        step();
        chk("pre_stall_out", 32'(out0), 32'h13);
        rdy = 1'b0;
        s   = 3'd6;
        repeat (4) begin
            step();
            chk("stall_out", 32'(out0), 32'h13);
            chk("stall_ch",  32'(ch0),  32'h3);
        end
        rdy = 1'b1;
        step();
        chk("release_out", 32'(out0), 32'h16);

        // Scan with DWELL=2: 0,0,1,1,...,7,7,0
        scan = 1'b1;
        for (int n = 0; n < 17; n++) begin
            step();
            chk("scan_ch",   32'(ch0), 32'((n / 2) % 8));
            chk("scan_wrap", 32'(w0),  32'(n == 15));
        end

        // Mode re-entry with the pointer parked mid-scan
        repeat (7) step();
        scan = 1'b0;
        repeat (2) step();
        scan = 1'b1;
        step();
        chk("reentry_ch", 32'(ch0), 32'h0);
        step();
        chk("reentry_dwell", 32'(ch0), 32'h0);
        step();
        chk("reentry_next", 32'(ch0), 32'h1);

        // Asynchronous reset in the middle of a stall
        rdy = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out",   32'(out0), 32'h0);
        chk("arst_valid", 32'(v0),   32'h0);
        chk("arst_wrap",  32'(w0),   32'h0);
        chk("arst_ch",    32'(ch0),  32'h0);
        model_reset();
        #2 rst_n = 1'b1;
        rdy = 1'b1;
        step();
        chk("post_rst_ch",    32'(ch0), 32'h0);
        chk("post_rst_valid", 32'(v0),  32'h1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            tb_i = {$urandom, $urandom};
            s    = 3'($urandom_range(0, 7));
            en   = ($urandom_range(0, 4) != 0);
            rdy  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 9) == 0) scan = ~scan;
            step();
        end

`ifdef SCANNING_MULTIPLEXER_MASK_EN
        // Masked scan: 0,0,3,3,4,4,6,6,0 with DWELL=2
        scan    = 1'b0;
        en      = 1'b1;
        rdy     = 1'b1;
        tb_mask = 8'b1010_0110;
        step();
        scan = 1'b1;
        for (int n = 0; n < 9; n++) begin
            step();
            chk("mask_wrap", 32'(w0), 32'(n == 7));
        end
        tb_mask = 8'hFF;
        repeat (2) step();
        chk("all_masked_valid", 32'(v0), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
